// File: rtl/cu_state_sequencer.sv
// Next-state half of the multicycle RISC-V control unit: control state register, latched opcode class,
// sticky halt and retired-instruction counter. One state per cycle with en high; en low freezes everything.
module cu_state_sequencer #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [6:0]          opcode,
  output logic [3:0]          StateRegister,
  output logic                halted,
  output logic                retire,
  output logic [RETIRE_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_LINK   = 4'd9,
    S_JAL    = 4'd10,
    S_AUIPC  = 4'd11,
    S_JALR   = 4'd12,
    S_EXEC_I = 4'd13,
    S_UNUSED = 4'd14,
    S_HALT   = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CLS_OTHER = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_JAL   = 3'd3,
    CLS_JALR  = 3'd4
  } cls_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [RETIRE_W-1:0] CNT_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic                halted_q, halted_d;
  logic                retire_q, retire_d;
  logic [RETIRE_W-1:0] count_q, count_d;

  state_e dec_state;
  cls_e   dec_cls;

  // Opcode decode, only consumed while sitting in the decode state.
  always_comb begin
    dec_state = S_HALT;
    dec_cls   = CLS_OTHER;
    case (opcode)
      OP_LOAD:   begin dec_state = S_MEMADR; dec_cls = CLS_LOAD;  end
      OP_STORE:  begin dec_state = S_MEMADR; dec_cls = CLS_STORE; end
      OP_RTYPE:  dec_state = S_EXEC_R;
      OP_ITYPE:  dec_state = S_EXEC_I;
      OP_BRANCH: dec_state = S_BRANCH;
      OP_JAL:    begin dec_state = S_LINK;   dec_cls = CLS_JAL;   end
      OP_JALR:   begin dec_state = S_LINK;   dec_cls = CLS_JALR;  end
      OP_AUIPC:  dec_state = S_AUIPC;
      default:   dec_state = S_HALT;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    halted_d = halted_q;
    retire_d = 1'b0;
    count_d  = count_q;
    if (en) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          state_d = dec_state;
          cls_d   = dec_cls;
          if (dec_state == S_HALT) halted_d = 1'b1;
        end
        // Shared states branch on the latched class so opcode may change after decode.
        S_MEMADR: begin
          if (cls_q == CLS_LOAD)       state_d = S_MEMRD;
          else if (cls_q == CLS_STORE) state_d = S_MEMWR;
          else                         state_d = S_FETCH;
        end
        S_MEMRD:  state_d = S_MEMWB;
        S_EXEC_R: state_d = S_ALUWB;
        S_EXEC_I: state_d = S_ALUWB;
        S_LINK: begin
          if (cls_q == CLS_JAL)       state_d = S_JAL;
          else if (cls_q == CLS_JALR) state_d = S_JALR;
          else                        state_d = S_FETCH;
        end
        S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JAL, S_AUIPC, S_JALR: begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end
        S_UNUSED: state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_FETCH;
      endcase
      if (retire_d) count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cls_q    <= CLS_OTHER;
      halted_q <= 1'b0;
      retire_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      halted_q <= halted_d;
      retire_q <= retire_d;
      count_q  <= count_d;
    end
  end

  assign StateRegister = state_q;
  assign halted        = halted_q;
  assign retire        = retire_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_cu_state_sequencer.sv
// Directed bench for cu_state_sequencer; a second instance with a 4-bit counter checks wrap-around.
module tb_cu_state_sequencer;

  logic        clk;
  logic        reset;
  logic        en;
  logic [6:0]  opcode;
  logic [3:0]  state;
  logic        halted;
  logic        retire;
  logic [31:0] cnt;
  logic [3:0]  state4;
  logic        halted4;
  logic        retire4;
  logic [3:0]  cnt4;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int exp_cnt = 0;

  cu_state_sequencer #(.RETIRE_W(32)) u_dut (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode),
    .StateRegister(state), .halted(halted), .retire(retire), .retired_count(cnt)
  );

  cu_state_sequencer #(.RETIRE_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode),
    .StateRegister(state4), .halted(halted4), .retire(retire4), .retired_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one instruction from state 0: seq lists the states expected after each edge, ending in 0.
  task automatic run_seq(input string tag, input logic [6:0] op, input int seq[5], input int n);
    opcode = op;
    en     = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("%s_state%0d", tag, i), {28'd0, state}, seq[i]);
      if (i < n - 1) check($sformatf("%s_noret%0d", tag, i), {31'd0, retire}, 0);
    end
    exp_cnt++;
    check({tag, "_retire"}, {31'd0, retire}, 1);
    check({tag, "_count"}, cnt, exp_cnt);
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    opcode = 7'd0;
    tick();
    tick();
    check("rst_state",  {28'd0, state},  0);
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_retire", {31'd0, retire}, 0);
    check("rst_count",  cnt, 0);
    reset = 1'b0;

    run_seq("load", 7'b0000011, '{1, 2, 3, 4, 0}, 5);

    // Store with opcode switched to R-type while in state 2: latched class must still pick 5.
    opcode = 7'b0100011;
    en     = 1'b1;
    tick();
    check("st_s1", {28'd0, state}, 1);
    tick();
    check("st_s2", {28'd0, state}, 2);
    opcode = 7'b0110011;
    tick();
    check("st_s5", {28'd0, state}, 5);
    tick();
    check("st_s0", {28'd0, state}, 0);
    exp_cnt++;
    check("st_retire", {31'd0, retire}, 1);
    check("st_count", cnt, exp_cnt);

    run_seq("rtype",  7'b0110011, '{1, 6, 7, 0, 0}, 4);
    check("after_st_r_count", cnt, 3);
    run_seq("jal",    7'b1101111, '{1, 9, 10, 0, 0}, 4);
    run_seq("jalr",   7'b1100111, '{1, 9, 12, 0, 0}, 4);
    run_seq("itype",  7'b0010011, '{1, 13, 7, 0, 0}, 4);
    run_seq("auipc",  7'b0010111, '{1, 11, 0, 0, 0}, 3);
    run_seq("branch", 7'b1100011, '{1, 8, 0, 0, 0}, 3);

    // en dropout of three cycles in state 3 of a load.
    opcode = 7'b0000011;
    tick();
    tick();
    tick();
    check("drop_s3", {28'd0, state}, 3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("drop_hold%0d", i), {28'd0, state}, 3);
      check($sformatf("drop_noret%0d", i), {31'd0, retire}, 0);
    end
    en = 1'b1;
    tick();
    check("drop_s4", {28'd0, state}, 4);
    tick();
    check("drop_s0", {28'd0, state}, 0);
    exp_cnt++;
    check("drop_retire", {31'd0, retire}, 1);
    check("drop_count", cnt, exp_cnt);
    en = 1'b0;
    tick();
    check("drop_retire_once", {31'd0, retire}, 0);
    check("drop_idle_state", {28'd0, state}, 0);

    // LUI is unsupported: halt, stay put with en toggling, then recover by reset.
    opcode = 7'b0110111;
    en     = 1'b1;
    tick();
    check("lui_s1", {28'd0, state}, 1);
    tick();
    check("lui_s15", {28'd0, state}, 15);
    check("lui_halted", {31'd0, halted}, 1);
    for (int i = 0; i < 20; i++) begin
      en = i[0];
      tick();
      check($sformatf("halt_hold%0d", i), {28'd0, state}, 15);
      check($sformatf("halt_sticky%0d", i), {31'd0, halted}, 1);
    end
    check("halt_count", cnt, exp_cnt);
    check("halt_noret", {31'd0, retire}, 0);
    en    = 1'b1;
    reset = 1'b1;
    tick();
    check("halt_rst_state", {28'd0, state}, 0);
    check("halt_rst_halted", {31'd0, halted}, 0);
    check("halt_rst_count", cnt, 0);
    reset   = 1'b0;
    exp_cnt = 0;

    // Reset asserted while in R-type execute.
    opcode = 7'b0110011;
    en     = 1'b1;
    tick();
    tick();
    check("rst6_in6", {28'd0, state}, 6);
    reset = 1'b1;
    tick();
    check("rst6_state", {28'd0, state}, 0);
    check("rst6_retire", {31'd0, retire}, 0);
    check("rst6_count", cnt, 0);
    reset = 1'b0;

    // 17 instructions: 32-bit counter reads 17, 4-bit counter wraps to 1.
    for (int k = 0; k < 17; k++) begin
      run_seq($sformatf("wrap%0d", k), 7'b1100011, '{1, 8, 0, 0, 0}, 3);
    end
    check("wrap_count32", cnt, 17);
    check("wrap_count4", {28'd0, cnt4}, 1);
    check("wrap_retire4", {31'd0, retire4}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cu_state_sequencer.md
# cu_state_sequencer

Next-state half of the multicycle RISC-V control unit. Holds the 4-bit control state register and advances it each cycle from the current state and the instruction opcode. Its `StateRegister` output drives the control-signal decoder that produces PCWrite, MemRead, ALUSrcB and the other control signals. It also latches the decoded opcode class, halts on unsupported opcodes, and counts retired instructions.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high; has priority over `en`.
- `en`, input, 1: advance enable. While low, every register holds.
- `opcode`, input, 7: `IR[6:0]`. Sampled only in state 1 (decode).
- `StateRegister`, output, 4: current control state; registered.
- `halted`, output, 1: sticky. Set on an illegal opcode; cleared only by reset.
- `retire`, output, 1: registered one-cycle pulse marking instruction completion.
- `retired_count`, output, RETIRE_W: number of completed instructions; wraps modulo 2^RETIRE_W.

## Operation
State encoding, which is fixed and shared with the decoder:
- 0: fetch
- 1: decode
- 2: memory address
- 3: memory read
- 4: load writeback
- 5: store
- 6: R-type execute
- 7: ALU writeback
- 8: branch
- 9: link, RF[rd] = PC+4
- 10: JAL target
- 11: AUIPC
- 12: JALR target
- 13: I-type ALU execute
- 14: unused
- 15: HALT

Transitions, taken only when `en` = 1:
- 0 -> 1.
- 1 -> by opcode:
  - 0000011 (load) -> 2
  - 0100011 (store) -> 2
  - 0110011 (R-type) -> 6
  - 0010011 (I-type ALU) -> 13
  - 1100011 (branch) -> 8
  - 1101111 (JAL) -> 9
  - 1100111 (JALR) -> 9
  - 0010111 (AUIPC) -> 11
  - any other opcode, including LUI, SYSTEM and FENCE -> 15, and `halted` is set.
- In state 1 the opcode class (load, store, jal, jalr, other) is latched into an internal register. States 2 and 9 decide their successor from this latched class, not from the live `opcode`.
- 2 -> 3 if class is load; 2 -> 5 if class is store.
- 3 -> 4.
- 6 -> 7; 13 -> 7.
- 9 -> 10 if class is jal; 9 -> 12 if class is jalr.
- Final states return to 0: 4, 5, 7, 8, 10, 11, 12.
- 15 -> 15 forever; `en` has no effect.
- 14 -> 0 as a recovery path. It does not retire an instruction and does not set `halted`.

Retire:
- `retire` is asserted for the cycle after a final state transitions to 0 with `en` = 1.
- `retired_count` increments on that same edge.

## Timing
- Reset values: `StateRegister` = 0, `halted` = 0, `retire` = 0, `retired_count` = 0, latched class cleared.
- Reset asserted mid-instruction, including in state 15, forces all of the above on the next edge. No retire is recorded.
- One state per enabled cycle. Instruction latencies in cycles, counting from state 0:
  - load: 5
  - store: 4
  - R-type and I-type ALU: 4
  - branch: 3
  - JAL and JALR: 4
  - AUIPC: 3
- `en` = 0: the state, class, `halted` and counter hold, and `retire` is driven 0 that cycle. A single-cycle `en` dropout therefore stretches latency by exactly one cycle.
- `opcode` only needs to be valid during state-1 cycles in which `en` = 1.
- `halted` rises on the same edge that enters 15.
- `retired_count` wraps from all-ones to 0 without any flag.

## Test plan
- Reset, then hold `en`=1 and present a load (`opcode` = 0000011) -> the sequence 0,1,2,3,4,0. `retire` pulses once and `retired_count` = 1.
- Store then R-type back to back -> states 0,1,2,5,0,1,6,7,0 and `retired_count` = 2. Changing `opcode` during state 2 does not alter the 2->5 decision.
- JAL then JALR -> 0,1,9,10,0 then 0,1,9,12,0. I-type ALU -> 0,1,13,7,0. AUIPC -> 0,1,11,0. Branch -> 0,1,8,0.
- `opcode` = 0110111 (LUI) in state 1 -> state 15 and `halted` = 1. The sequencer stays there for 20 cycles with `en` toggling, and `retired_count` is unchanged. Then `reset` -> state 0 and `halted` = 0.
- Lower `en` for 3 cycles during state 3 of a load -> state 3 holds for 4 cycles total, then 4, 0. `retire` fires exactly once.
- Assert `reset` during state 6 -> next cycle `StateRegister` = 0 and `retire` = 0. Separately, with `RETIRE_W` = 4, run 17 instructions -> `retired_count` = 1.
